// File: rtl/gcm_pkg.sv
// Shared constants, phase encodings and tagger FSM states for the AES-GCM
// datapath. The phase bypasser imports the same phase encodings.
package gcm_pkg;

    localparam int DATA_W = 256;
    localparam int TEXT_W = 289;
    localparam int BLK_W  = 128;
    localparam int IV_W   = 96;
    localparam int CTR_W  = 32;

    // One-hot packet phase carried on o_state; 0 means idle.
    localparam logic [3:0] PKT_FIRST_WORD  = 4'd1;
    localparam logic [3:0] PKT_SECOND_WORD = 4'd2;
    localparam logic [3:0] PKT_INNER_WORD  = 4'd4;

    // Largest byte count that still fits; the count saturates here.
    localparam logic [31:0] BYTE_CNT_MAX = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SECOND = 3'd2,
        ST_INNER  = 3'd3,
        ST_GAP    = 3'd4
    } tagger_state_e;

    // Byte offset of the following word, saturating instead of wrapping.
    function automatic logic [31:0] next_byte_count(input logic [31:0] bc);
        return (bc == BYTE_CNT_MAX) ? bc : bc + 32'd32;
    endfunction

endpackage

// File: rtl/gcm_ctr_gen.sv
// Counter-block generator: holds IV and the two ctr32 values of the word
// currently on the output. load starts a packet at ctr_init, step advances
// both blocks by two. ctr32 arithmetic is mod 2^32 and never carries into IV.
module gcm_ctr_gen
    import gcm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [IV_W-1:0]    iv_in,
    input  logic [CTR_W-1:0]   ctr_init,
    output logic [2*BLK_W-1:0] ctr_blk
);

    logic [IV_W-1:0]  iv_q;
    logic [CTR_W-1:0] c0_q;
    logic [CTR_W-1:0] c1_q;

    // Latch IV and first counter pair on load; advance by two on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q <= '0;
            c0_q <= '0;
            c1_q <= '0;
        end else if (load) begin
            iv_q <= iv_in;
            c0_q <= ctr_init;
            c1_q <= ctr_init + 32'd1;
        end else if (step) begin
            c0_q <= c1_q + 32'd1;
            c1_q <= c1_q + 32'd2;
        end
    end

    assign ctr_blk = {iv_q, c0_q, iv_q, c1_q};

endmodule

// File: rtl/gcm_word_tagger.sv
// Packet framing stage ahead of the AES-GCM core: tags each accepted word
// with its phase and last flag, builds the 289-bit text word and the pair of
// IV||ctr32 counter blocks. One register stage, one word per cycle.
// Optional feature macro: GCM_TAGGER_LEN_CHECK_EN enables the per-packet
// word-count versus header-length check driving o_len_err.
//
// Handshake: an input word transfers on a rising edge where s_valid and
// s_ready are both 1; s_ready is registered and never depends on s_valid.
// The output side has no backpressure: o_ready is a one-cycle strobe marking
// a new word, and the other outputs hold between strobes.
module gcm_word_tagger
    import gcm_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic [3:0]         o_state,
    output logic               o_last,
    output logic [TEXT_W-1:0]  o_text,
    output logic [2*BLK_W-1:0] o_ctr,
    output logic               o_ready,
    output logic               o_err,
    output logic               o_len_err,
    output logic [2:0]         dbg_state
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    tagger_state_e    state;
    tagger_state_e    state_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      bc_q;

    logic        accept;
    logic        in_pkt;
    logic        start_pkt;
    logic        cont_pkt;
    logic        bad_word;
    logic        emit;
    logic [3:0]  emit_phase;
    logic [31:0] bc_next;

    assign dbg_state = state;

    // Classify the current input word and work out the next FSM state.
    always_comb begin
        accept     = s_valid && s_ready;
        in_pkt     = (state == ST_FIRST) || (state == ST_SECOND) || (state == ST_INNER);
        // A sop always opens a packet, even if it abandons one in flight.
        start_pkt  = accept && s_sop;
        cont_pkt   = accept && !s_sop && in_pkt;
        bad_word   = accept && (in_pkt ? s_sop : !s_sop);
        emit       = start_pkt || cont_pkt;
        emit_phase = start_pkt ? PKT_FIRST_WORD :
                     (state == ST_INNER) ? PKT_INNER_WORD : PKT_SECOND_WORD;
        bc_next    = start_pkt ? 32'd0 : next_byte_count(bc_q);
        state_next = state;
        if (state == ST_GAP) begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = ST_IDLE;
        end else if (emit) begin
            if (s_eop)          state_next = ST_GAP;
            else if (start_pkt) state_next = ST_SECOND;
            else                state_next = ST_INNER;
        end
    end

    // Tagger FSM with registered outputs and registered s_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            bc_q    <= '0;
            s_ready <= 1'b0;
            o_state <= '0;
            o_last  <= 1'b0;
            o_text  <= '0;
            o_ready <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_next;
            s_ready <= (state_next != ST_GAP);
            o_ready <= emit;
            o_err   <= bad_word;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (emit) begin
                bc_q    <= bc_next;
                o_state <= emit_phase;
                o_last  <= s_eop;
                o_text  <= {start_pkt, bc_next, s_data};
            end
        end
    end

    gcm_ctr_gen u_ctr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_pkt),
        .step     (cont_pkt),
        .iv_in    (s_data[IV_W-1:0]),
        .ctr_init (32'd1),
        .ctr_blk  (o_ctr)
    );

`ifdef GCM_TAGGER_LEN_CHECK_EN
    logic [15:0] len_q;
    logic [15:0] len_now;
    logic [31:0] wcnt_q;
    logic [31:0] wcnt_now;
    logic [31:0] words_exp;

    // Word count including this word, and the count the header length implies.
    always_comb begin
        len_now   = start_pkt ? s_data[111:96] : len_q;
        wcnt_now  = start_pkt ? 32'd1 : wcnt_q + 32'd1;
        words_exp = (32'(len_now) + 32'd31) >> 5;
    end

    // Track length and word count per packet; flag a mismatch on the eop word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            wcnt_q    <= '0;
            o_len_err <= 1'b0;
        end else begin
            o_len_err <= 1'b0;
            if (emit) begin
                len_q     <= len_now;
                wcnt_q    <= wcnt_now;
                o_len_err <= s_eop && (wcnt_now != words_exp);
            end
        end
    end
`else
    assign o_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_word_tagger.sv
// Directed self-checking bench for gcm_word_tagger and its counter generator.
module tb_gcm_word_tagger;
    import gcm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [255:0] s_data = '0;
    logic         s_sop = 1'b0;
    logic         s_eop = 1'b0;
    logic [3:0]   o_state;
    logic         o_last;
    logic [288:0] o_text;
    logic [255:0] o_ctr;
    logic         o_ready;
    logic         o_err;
    logic         o_len_err;
    logic [2:0]   dbg_state;

    logic         cg_load = 1'b0;
    logic         cg_step = 1'b0;
    logic [95:0]  cg_iv = '0;
    logic [31:0]  cg_init = '0;
    logic [255:0] cg_blk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_q[$];

`ifdef GCM_TAGGER_LEN_CHECK_EN
    localparam logic LEN_ON = 1'b1;
`else
    localparam logic LEN_ON = 1'b0;
`endif

    gcm_word_tagger #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .o_state(o_state),
        .o_last(o_last), .o_text(o_text), .o_ctr(o_ctr), .o_ready(o_ready),
        .o_err(o_err), .o_len_err(o_len_err), .dbg_state(dbg_state)
    );

    gcm_ctr_gen u_ctr (
        .clk(clk), .rst_n(rst_n), .load(cg_load), .step(cg_step),
        .iv_in(cg_iv), .ctr_init(cg_init), .ctr_blk(cg_blk)
    );

    // ---------------- models ----------------
    function automatic logic [255:0] hdr(input logic [95:0] iv, input logic [15:0] len);
        return {144'h0, len, iv};
    endfunction

    function automatic logic [255:0] exp_ctr(input logic [95:0] iv, input int k);
        logic [31:0] a;
        logic [31:0] b;
        a = 32'(2 * k + 1);
        b = 32'(2 * k + 2);
        return {iv, a, iv, b};
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle of input, pass the edge, return 1ns later for sampling.
    task automatic put(input logic v, input logic sop, input logic eop, input logic [255:0] d);
        s_valid = v;
        s_sop   = sop;
        s_eop   = eop;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
        n_tests++; if (o_state !== 4'd0) begin n_fail++; $display("FAIL rst_o_state: got %h exp 0", o_state); end
        n_tests++; if (o_text !== '0) begin n_fail++; $display("FAIL rst_o_text: got %h exp 0", o_text); end
        n_tests++; if (o_ctr !== '0) begin n_fail++; $display("FAIL rst_o_ctr: got %h exp 0", o_ctr); end
        n_tests++; if ({o_last, o_ready, o_err, o_len_err} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b exp 0000", {o_last, o_ready, o_err, o_len_err}); end
        rst_n = 1'b1;
        idle(1);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", s_ready); end
    endtask

    task automatic test_three_word();
        logic [95:0]  iv;
        logic [255:0] d[3];
        logic [255:0] e;
        iv   = 96'h0123_4567_89AB_CDEF_0123_45AB;
        d[0] = hdr(iv, 16'd96);
        d[1] = {8{32'hA5A5_0001}};
        d[2] = {8{32'h5A5A_0002}};
        for (int k = 0; k < 3; k++) exp_q.push_back(exp_ctr(iv, k));
        for (int k = 0; k < 3; k++) begin
            put(1'b1, k == 0, k == 2, d[k]);
            e = exp_q.pop_front();
            n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL three_ready_w%0d: got %b exp 1", k, o_ready); end
            n_tests++; if (o_state !== (4'd1 << k)) begin n_fail++; $display("FAIL three_state_w%0d: got %h exp %h", k, o_state, 4'd1 << k); end
            n_tests++; if (o_ctr !== e) begin n_fail++; $display("FAIL three_ctr_w%0d: got %h exp %h", k, o_ctr, e); end
            n_tests++; if (o_text !== {k == 0, 32'(k * 32), d[k]}) begin
                n_fail++; $display("FAIL three_text_w%0d: got %h exp %h", k, o_text, {k == 0, 32'(k * 32), d[k]}); end
            n_tests++; if (o_last !== (k == 2)) begin n_fail++; $display("FAIL three_last_w%0d: got %b exp %b", k, o_last, k == 2); end
            n_tests++; if (s_ready !== (k != 2)) begin n_fail++; $display("FAIL three_s_ready_w%0d: got %b exp %b", k, s_ready, k != 2); end
        end
        n_tests++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL three_len_err: got %b exp 0", o_len_err); end
        // Offer a sop during the gap: it must not be taken.
        put(1'b1, 1'b1, 1'b0, hdr(96'h1, 16'd32));
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL gap1_s_ready: got %b exp 0", s_ready); end
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL gap1_o_ready: got %b exp 0", o_ready); end
        n_tests++; if (o_state !== 4'd4) begin n_fail++; $display("FAIL gap1_hold_state: got %h exp 4", o_state); end
        n_tests++; if (dbg_state !== ST_GAP) begin n_fail++; $display("FAIL gap1_dbg_state: got %h exp %h", dbg_state, ST_GAP); end
        idle(1);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL gap2_s_ready: got %b exp 1", s_ready); end
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL gap2_o_ready: got %b exp 0", o_ready); end
    endtask

    task automatic test_single_word();
        logic [95:0]  iv;
        logic [255:0] d;
        iv = 96'hFEED_FACE_CAFE_BEEF_1234_5678;
        d  = hdr(iv, 16'd32);
        put(1'b1, 1'b1, 1'b1, d);
        n_tests++; if (o_state !== 4'd1) begin n_fail++; $display("FAIL single_state: got %h exp 1", o_state); end
        n_tests++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b exp 1", o_last); end
        n_tests++; if (o_text !== {1'b1, 32'd0, d}) begin n_fail++; $display("FAIL single_text: got %h exp %h", o_text, {1'b1, 32'd0, d}); end
        n_tests++; if (o_ctr !== exp_ctr(iv, 0)) begin n_fail++; $display("FAIL single_ctr: got %h exp %h", o_ctr, exp_ctr(iv, 0)); end
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL single_gap: got %b exp 0", s_ready); end
        n_tests++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL single_len_err: got %b exp 0", o_len_err); end
        idle(2);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b exp 1", s_ready); end
    endtask

    task automatic test_ctr_wrap();
        logic [95:0] iv;
        iv = 96'hDEAD_BEEF_0000_0000_FFFF_FFFF;
        cg_iv = iv; cg_init = 32'hFFFF_FFFE; cg_load = 1'b1;
        @(posedge clk); #1;
        cg_load = 1'b0; cg_iv = '0;
        n_tests++; if (cg_blk !== {iv, 32'hFFFF_FFFE, iv, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL wrap_load: got %h exp %h", cg_blk, {iv, 32'hFFFF_FFFE, iv, 32'hFFFF_FFFF}); end
        cg_step = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (cg_blk !== {iv, 32'h0000_0000, iv, 32'h0000_0001}) begin
            n_fail++; $display("FAIL wrap_step1: got %h exp %h", cg_blk, {iv, 32'h0, iv, 32'h1}); end
        @(posedge clk); #1;
        cg_step = 1'b0;
        n_tests++; if (cg_blk !== {iv, 32'h0000_0002, iv, 32'h0000_0003}) begin
            n_fail++; $display("FAIL wrap_step2: got %h exp %h", cg_blk, {iv, 32'h2, iv, 32'h3}); end
    endtask

    task automatic test_errors();
        logic [95:0]  iv_a;
        logic [95:0]  iv_b;
        logic [255:0] w;
        iv_a = 96'h1111_2222_3333_4444_5555_6666;
        iv_b = 96'h7777_8888_9999_AAAA_BBBB_CCCC;
        w    = {4{64'h0F0F_0F0F_F0F0_F0F0}};
        put(1'b1, 1'b0, 1'b0, w);
        n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL nosop_err: got %b exp 1", o_err); end
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL nosop_ready: got %b exp 0", o_ready); end
        idle(1);
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL nosop_pulse: got %b exp 0", o_err); end
        put(1'b1, 1'b1, 1'b0, hdr(iv_a, 16'd64));
        put(1'b1, 1'b0, 1'b0, w);
        n_tests++; if (o_ctr !== exp_ctr(iv_a, 1)) begin n_fail++; $display("FAIL midsop_pre_ctr: got %h exp %h", o_ctr, exp_ctr(iv_a, 1)); end
        put(1'b1, 1'b1, 1'b0, hdr(iv_b, 16'd64));
        n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL midsop_err: got %b exp 1", o_err); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midsop_ready: got %b exp 1", o_ready); end
        n_tests++; if (o_state !== 4'd1) begin n_fail++; $display("FAIL midsop_state: got %h exp 1", o_state); end
        n_tests++; if (o_ctr !== exp_ctr(iv_b, 0)) begin n_fail++; $display("FAIL midsop_ctr: got %h exp %h", o_ctr, exp_ctr(iv_b, 0)); end
        n_tests++; if (o_text[288] !== 1'b1 || o_last !== 1'b0) begin
            n_fail++; $display("FAIL midsop_sop_last: got %b%b exp 10", o_text[288], o_last); end
        put(1'b1, 1'b0, 1'b1, w);
        n_tests++; if (o_state !== 4'd2 || o_last !== 1'b1) begin
            n_fail++; $display("FAIL midsop_end: got state %h last %b exp 2 1", o_state, o_last); end
        n_tests++; if (o_ctr !== exp_ctr(iv_b, 1)) begin n_fail++; $display("FAIL midsop_end_ctr: got %h exp %h", o_ctr, exp_ctr(iv_b, 1)); end
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL midsop_end_err: got %b exp 0", o_err); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [95:0]  iv_c;
        logic [95:0]  iv_d;
        logic [255:0] w;
        iv_c = 96'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
        iv_d = 96'hD00D_D00D_0000_1111_2222_3333;
        w    = {8{32'h1357_9BDF}};
        put(1'b1, 1'b1, 1'b0, hdr(iv_c, 16'd128));
        put(1'b1, 1'b0, 1'b0, w);
        put(1'b1, 1'b0, 1'b0, w);
        n_tests++; if (o_state !== 4'd4) begin n_fail++; $display("FAIL mid_inner_state: got %h exp 4", o_state); end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (o_state !== 4'd0 || o_text !== '0 || o_ctr !== '0) begin
            n_fail++; $display("FAIL mid_rst_data: got state %h text %h ctr %h exp 0", o_state, o_text, o_ctr); end
        n_tests++; if ({s_ready, o_last, o_ready, o_err, o_len_err} !== 5'b0) begin
            n_fail++; $display("FAIL mid_rst_flags: got %b exp 00000", {s_ready, o_last, o_ready, o_err, o_len_err}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b exp 1", s_ready); end
        put(1'b1, 1'b1, 1'b0, hdr(iv_d, 16'd64));
        n_tests++; if (o_state !== 4'd1 || o_ctr !== exp_ctr(iv_d, 0)) begin
            n_fail++; $display("FAIL fresh_w0: got state %h ctr %h exp 1 %h", o_state, o_ctr, exp_ctr(iv_d, 0)); end
        put(1'b1, 1'b0, 1'b1, w);
        n_tests++; if (o_state !== 4'd2 || o_ctr !== exp_ctr(iv_d, 1)) begin
            n_fail++; $display("FAIL fresh_w1: got state %h ctr %h exp 2 %h", o_state, o_ctr, exp_ctr(iv_d, 1)); end
        n_tests++; if (o_text !== {1'b0, 32'd32, w} || o_last !== 1'b1) begin
            n_fail++; $display("FAIL fresh_w1_text: got %h last %b exp %h 1", o_text, o_last, {1'b0, 32'd32, w}); end
        idle(2);
    endtask

    task automatic test_len_check();
        logic [95:0]  iv;
        logic [255:0] w;
        iv = 96'hE0E0_0000_1111_2222_3333_4444;
        w  = {8{32'h2468_ACE0}};
        put(1'b1, 1'b1, 1'b0, hdr(iv, 16'd96));
        n_tests++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL len2_hdr: got %b exp 0", o_len_err); end
        put(1'b1, 1'b0, 1'b1, w);
        n_tests++; if (o_len_err !== LEN_ON) begin n_fail++; $display("FAIL len2_eop: got %b exp %b", o_len_err, LEN_ON); end
        idle(1);
        n_tests++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL len2_pulse: got %b exp 0", o_len_err); end
        idle(1);
        put(1'b1, 1'b1, 1'b0, hdr(iv, 16'd96));
        put(1'b1, 1'b0, 1'b0, w);
        put(1'b1, 1'b0, 1'b1, w);
        n_tests++; if (o_len_err !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL len3_eop: got len_err %b ready %b exp 0 1", o_len_err, o_ready); end
        idle(2);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_three_word();
        test_single_word();
        test_ctr_wrap();
        test_errors();
        test_reset_mid();
        test_len_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
